quad_delta_frontend: RTL and testbench
======================================

Name: quad_delta_frontend

Overview:
- Input conditioning stage directly upstream of the paddle position logic.
- Takes the raw, asynchronous quadrature encoder channels for one paddle and synchronizes and debounces them, then decodes direction.
- Accumulates a saturating signed step count over each video frame.
- Hands the per-frame delta to the paddle/pong logic once per frame, at the start of vertical sync from the sync generator.
- One instance per player.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer; minimum 2.
- DEBOUNCE_CYCLES, 256: consecutive clk cycles a synchronized level must differ from the clean level before the clean level changes; minimum 1.
- DELTA_W, 8: width of the signed accumulator and of the delta output.
- VSYNC_ACTIVE_LOW, 1: 1 means the frame strobe is the high-to-low edge of vsync; 0 means the low-to-high edge.

Ports:
- clk  input  1  system/pixel clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  1  raw encoder channel A; asynchronous to clk.
- b  input  1  raw encoder channel B; asynchronous to clk.
- vsync  input  1  vertical sync from the sync generator; synchronous to clk.
- delta  output  DELTA_W  signed two's-complement steps counted during the previous frame; held between strobes.
- delta_valid  output  1  one-cycle pulse in the cycle delta updates.
- a_clean  output  1  debounced channel A.
- b_clean  output  1  debounced channel B.
- err  output  1  one-cycle pulse on an illegal quadrature transition.

Behaviour:
- Reset (async assert, sync release):
  - all synchronizer flops, a_clean, b_clean, prev-state register, debounce counters, accumulator and registered vsync clear to 0.
  - delta = 0, delta_valid = 0, err = 0.
  - Reset mid-frame discards the partial count; no delta_valid is issued for the interrupted frame.
- Synchronizer: a and b each pass through SYNC_STAGES flops, giving a_s and b_s.
- Debounce (per channel, independent):
  - counter cnt of width clog2(DEBOUNCE_CYCLES+1).
  - If x_s == x_clean: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: x_clean <= x_s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches x_clean.
  - Latency from a stable raw edge to the clean edge is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Quadrature decode:
  - cur = {a_clean, b_clean}; prev is registered every cycle.
  - Up sequence: 00->01->11->10->00. Down sequence is the reverse.
  - cur == prev: no step.
  - Both bits differ: err = 1 for one cycle, no step, prev still updates to cur.
  - Step qualification (x1 mode, the default): only transitions into 00 count. 10->00 = +1, 01->00 = -1. All other legal transitions give step 0.
- Accumulator acc (signed DELTA_W):
  - acc <= sat(acc + step).
  - Clamps at +(2^(DELTA_W-1)-1) and -(2^(DELTA_W-1)). At a limit, further steps in the same direction are dropped; opposite steps apply normally.
- Frame strobe:
  - vsync_q is registered vsync.
  - strobe = vsync_q & ~vsync when VSYNC_ACTIVE_LOW=1, else ~vsync_q & vsync.
  - On strobe: delta <= sat(acc + step), acc <= 0, delta_valid <= 1. A step in the strobe cycle is counted in the closing frame, not lost.
  - delta_valid is registered: it rises the cycle after the strobe edge is seen and lasts exactly one cycle.
  - Back-to-back frames with no motion produce delta = 0 with delta_valid still pulsing.

Optional Feature:
- Macro QUAD_X4_EN.
- Defined: every legal single-bit transition counts.
  - Up sequence transitions = +1 each; down = -1 each.
  - Four counts per full quadrature cycle.
  - Illegal-transition and saturation rules are unchanged.
- Undefined: x1 mode as described in Behaviour; one count per full cycle.

Test Plan:
- Reset held, then released with a=b=0 and vsync toggling → delta=0, delta_valid pulses once per frame, err=0, a_clean=b_clean=0.
- Raw a pulse 0->1 lasting DEBOUNCE_CYCLES-1 cycles → a_clean stays 0. Pulse lasting DEBOUNCE_CYCLES → a_clean rises exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the raw edge.
- Three full up cycles (00,01,11,10,00 ×3), each level held 300 cycles, then one strobe → delta=+3 in x1 mode; delta=+12 with QUAD_X4_EN.
- 200 full down cycles within one frame with DELTA_W=8 → delta=-128 (saturated). Next frame with 5 up cycles → delta=+5.
- Force a_clean/b_clean from 00 to 11 in one cycle (both raw inputs flipped together) → err high for exactly 1 cycle, delta unaffected at the next strobe.
- Final step (10->00) lands on the same cycle as the vsync falling edge, acc=+2 → delta=+3, acc restarts at 0, the following frame reports 0.

Source files
------------

// File: rtl/quad_delta_frontend.sv
// Quadrature encoder front end: synchronize, debounce, decode and accumulate one paddle's steps per frame.
// Define QUAD_X4_EN to count every legal transition (x4); default counts one step per full cycle (x1).
module quad_delta_frontend #(
   parameter int SYNC_STAGES      = 2,
   parameter int DEBOUNCE_CYCLES  = 256,
   parameter int DELTA_W          = 8,
   parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               a,
   input  logic               b,
   input  logic               vsync,
   output logic [DELTA_W-1:0] delta,
   output logic               delta_valid,
   output logic               a_clean,
   output logic               b_clean,
   output logic               err
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]         w_raw;
   logic [1:0]         w_clean;
   logic [1:0]         r_prev;
   logic               r_vsync_q;
   logic               w_strobe;
   logic               w_illegal;
   logic [1:0]         w_step;
   logic [DELTA_W:0]   w_sum;
   logic [DELTA_W-1:0] w_sat;
   logic [DELTA_W-1:0] r_acc;
   logic [DELTA_W-1:0] r_delta;
   logic               r_delta_valid;
   logic               r_err;

   // Channel index 1 is A, index 0 is B, so {a,b} lines up with the decode tables.
   assign w_raw = {a, b};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] r_sync;
         logic                   r_clean;
         logic [CNT_W-1:0]       r_cnt;
         logic                   w_s;

         assign w_s = r_sync[SYNC_STAGES-1];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_sync  <= '0;
               r_clean <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
               if (w_s == r_clean) begin
                  r_cnt <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_clean <= w_s;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         assign w_clean[gi] = r_clean;
      end
   endgenerate

   // Step is a 2-bit two's-complement value: 01 = +1, 11 = -1, 00 = none.
   always_comb begin
      w_step    = 2'b00;
      w_illegal = ((w_clean ^ r_prev) == 2'b11);
`ifdef QUAD_X4_EN
      case ({r_prev, w_clean})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: w_step = 2'b01;
         4'b0010, 4'b1011, 4'b1101, 4'b0100: w_step = 2'b11;
         default:                            w_step = 2'b00;
      endcase
`else
      case ({r_prev, w_clean})
         4'b1000: w_step = 2'b01;
         4'b0100: w_step = 2'b11;
         default: w_step = 2'b00;
      endcase
`endif
   end

   // One extra bit exposes overflow; with |step| <= 1 the sign bit says which rail to clamp to.
   assign w_sum = {r_acc[DELTA_W-1], r_acc} + {{(DELTA_W-1){w_step[1]}}, w_step};
   assign w_sat = (w_sum[DELTA_W] ^ w_sum[DELTA_W-1])
                ? (w_sum[DELTA_W] ? {1'b1, {(DELTA_W-1){1'b0}}} : {1'b0, {(DELTA_W-1){1'b1}}})
                : w_sum[DELTA_W-1:0];

   assign w_strobe = VSYNC_ACTIVE_LOW ? (r_vsync_q & ~vsync) : (~r_vsync_q & vsync);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev        <= 2'b00;
         r_vsync_q     <= 1'b0;
         r_err         <= 1'b0;
         r_delta_valid <= 1'b0;
         r_delta       <= '0;
         r_acc         <= '0;
      end else begin
         r_prev        <= w_clean;
         r_vsync_q     <= vsync;
         r_err         <= w_illegal;
         r_delta_valid <= w_strobe;
         // A step arriving on the strobe cycle closes into this frame's delta.
         if (w_strobe) begin
            r_delta <= w_sat;
            r_acc   <= '0;
         end else begin
            r_acc   <= w_sat;
         end
      end
   end

   assign delta       = r_delta;
   assign delta_valid = r_delta_valid;
   assign a_clean     = w_clean[1];
   assign b_clean     = w_clean[0];
   assign err         = r_err;

endmodule

// File: tb/tb_quad_delta_frontend.sv
// Directed bench for quad_delta_frontend: debounce timing, x1/x4 counting, saturation, illegal moves, strobe edge cases.
module tb_quad_delta_frontend;

   localparam int S = 2;
   localparam int D = 4;
   localparam int H = 10;
`ifdef QUAD_X4_EN
   localparam int MULT = 4;
`else
   localparam int MULT = 1;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              a;
   logic              b;
   logic              vsync;
   logic signed [7:0] delta;
   logic              delta_valid;
   logic              a_clean;
   logic              b_clean;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;
   int err_cnt  = 0;

   quad_delta_frontend #(
      .SYNC_STAGES      (S),
      .DEBOUNCE_CYCLES  (D),
      .DELTA_W          (8),
      .VSYNC_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .a           (a),
      .b           (b),
      .vsync       (vsync),
      .delta       (delta),
      .delta_valid (delta_valid),
      .a_clean     (a_clean),
      .b_clean     (b_clean),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && err) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic set_ab(input logic va, input logic vb);
      @(posedge clk);
      #1;
      a = va;
      b = vb;
      repeat (H - 1) @(posedge clk);
   endtask

   task automatic up_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_ab(1'b0, 1'b1);
         set_ab(1'b1, 1'b1);
         set_ab(1'b1, 1'b0);
         set_ab(1'b0, 1'b0);
      end
   endtask

   task automatic down_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_ab(1'b1, 1'b0);
         set_ab(1'b1, 1'b1);
         set_ab(1'b0, 1'b1);
         set_ab(1'b0, 1'b0);
      end
   endtask

   // Expects vsync already driven low just after a clock edge.
   task automatic wait_valid(input string tag, input int exp);
      int seen_at;
      seen_at = -1;
      for (int n = 0; n < 6 && seen_at < 0; n++) begin
         @(negedge clk);
         if (delta_valid) seen_at = n;
      end
      check({tag, "_lat"}, seen_at, 1);
      if (seen_at >= 0) begin
         check(tag, int'(delta), exp);
         @(negedge clk);
         check({tag, "_width"}, int'(delta_valid), 0);
      end
      @(posedge clk);
      #1 vsync = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic do_strobe(input string tag, input int exp);
      @(posedge clk);
      #1 vsync = 1'b0;
      wait_valid(tag, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int lat_at;
      int hi_seen;
      int e0;

      reset = 1'b1;
      a = 1'b0;
      b = 1'b0;
      vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_delta", int'(delta), 0);
      check("rst_valid", int'(delta_valid), 0);
      check("rst_err", int'(err), 0);
      check("rst_a_clean", int'(a_clean), 0);
      check("rst_b_clean", int'(b_clean), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(posedge clk);

      do_strobe("idle0", 0);
      do_strobe("idle1", 0);
      check("idle_err", err_cnt, 0);
      check("idle_clean", int'({a_clean, b_clean}), 0);

      // Glitch of D-1 cycles must never reach a_clean.
      hi_seen = 0;
      @(posedge clk);
      #1 a = 1'b1;
      for (lat = 1; lat <= 20; lat++) begin
         @(posedge clk);
         #1;
         if (a_clean) hi_seen = 1;
         if (lat == D - 1) a = 1'b0;
      end
      check("glitch_blocked", hi_seen, 0);

      // Pulse of exactly D cycles passes after S+D edges.
      lat_at = -1;
      @(posedge clk);
      #1 a = 1'b1;
      for (lat = 1; lat <= 20; lat++) begin
         @(posedge clk);
         #1;
         if (a_clean && lat_at < 0) lat_at = lat;
         if (lat == D) a = 1'b0;
      end
      check("debounce_latency", lat_at, S + D);

      // Mid-frame reset discards the partial count from the pulse above.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(posedge clk);
      do_strobe("after_reset", 0);

      up_cycles(3);
      do_strobe("up3", 3 * MULT);

      e0 = err_cnt;
      set_ab(1'b1, 1'b1);
      check("illegal_clean", int'({a_clean, b_clean}), 3);
      check("illegal_err_once", err_cnt - e0, 1);
      set_ab(1'b0, 1'b0);
      check("illegal_back_err", err_cnt - e0, 2);
      do_strobe("illegal_delta", 0);

      down_cycles(200);
      do_strobe("down_sat", -128);
      up_cycles(5);
      do_strobe("up5", 5 * MULT);

      // Final 10->00 step lands exactly on the strobe cycle.
      up_cycles(2);
      set_ab(1'b0, 1'b1);
      set_ab(1'b1, 1'b1);
      set_ab(1'b1, 1'b0);
      @(posedge clk);
      #1;
      a = 1'b0;
      b = 1'b0;
      repeat (S + D) @(posedge clk);
      #1 vsync = 1'b0;
      wait_valid("coincide", 3 * MULT);
      do_strobe("after_coincide", 0);
      check("final_err", err_cnt - e0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
